cluster_locate: RTL and testbench



---
 rtl/cluster_locate.sv | 187 ++++++++++++++++++
 tb/tb_cluster_locate.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cluster_locate.sv
// cluster_locate: finds the strongest contiguous above-threshold channel run by snooping signal-RAM writes.
// Optional: define CLUSTER_GAP_MERGE_EN to let a single below-threshold channel bridge a run.
module cluster_locate #(
  parameter int CH_NUM    = 320,
  parameter int MIN_WIDTH = 2,
  parameter int PAD       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bkg_sub_on,
  input  logic        sig_wren,
  input  logic [8:0]  sig_wraddress,
  input  logic [31:0] sig_wrdata,
  input  logic        sig_ram_last,
  input  logic [15:0] threshold,
  output logic [8:0]  sig_ch_left,
  output logic [8:0]  sig_ch_right,
  output logic        has_cluster,
  output logic        no_cluster,
  output logic [23:0] cluster_sum,
  output logic        seq_error
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [8:0] MIN_W  = 9'(MIN_WIDTH);
  localparam logic [9:0] PAD_W  = 10'(PAD);
  localparam logic [9:0] CH_MAX = 10'(CH_NUM - 1);

  state_t      state, state_nxt;
  logic        run_open, run_open_d, gap_pending, gap_d;
  logic [8:0]  run_start, run_start_d, run_end, run_end_d, run_cnt, run_cnt_d;
  logic [23:0] run_sum, run_sum_d, best_sum, best_sum_d;
  logic        best_valid, best_valid_d;
  logic [8:0]  best_start, best_start_d, best_end, best_end_d, prev_addr, prev_addr_d;
  logic        seq_q, seq_d, has_q, has_d, no_q, no_d;
  logic        frame_start, active, above, close_now;
  logic [23:0] mag;
  logic [9:0]  right_ext;
  logic        unused_hi;

  assign unused_hi = ^sig_wrdata[31:16];

  // Address 0 always (re)starts a frame; a lone sig_ram_last write in IDLE is a one-sample frame.
  assign frame_start = sig_wren && ((sig_wraddress == 9'd0) || (state == IDLE && sig_ram_last));
  assign active      = sig_wren && (frame_start || state == SCAN);
  assign above       = $signed(sig_wrdata[15:0]) > $signed(threshold);
  assign mag         = sig_wrdata[15] ? 24'd0 : {9'd0, sig_wrdata[14:0]};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (active) state_nxt = sig_ram_last ? DONE : SCAN;
  end

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    run_open_d   = run_open;
    gap_d        = gap_pending;
    run_start_d  = run_start;
    run_end_d    = run_end;
    run_cnt_d    = run_cnt;
    run_sum_d    = run_sum;
    best_valid_d = best_valid;
    best_start_d = best_start;
    best_end_d   = best_end;
    best_sum_d   = best_sum;
    prev_addr_d  = prev_addr;
    seq_d        = seq_q;
    has_d        = has_q;
    no_d         = no_q;
    close_now    = 1'b0;
    if (frame_start) begin
      run_open_d   = 1'b0;
      gap_d        = 1'b0;
      run_start_d  = '0;
      run_end_d    = '0;
      run_cnt_d    = '0;
      run_sum_d    = '0;
      best_valid_d = 1'b0;
      best_start_d = '0;
      best_end_d   = '0;
      best_sum_d   = '0;
      seq_d        = 1'b0;
      has_d        = 1'b0;
      no_d         = 1'b0;
    end
    if (active) begin
      if (!frame_start && sig_wraddress != prev_addr + 9'd1) seq_d = 1'b1;
      prev_addr_d = sig_wraddress;
      if (above) begin
        if (run_open_d) begin
          run_end_d = sig_wraddress;
          run_sum_d = run_sum_d + mag;
          run_cnt_d = run_cnt_d + 9'd1;
        end else begin
          run_open_d  = 1'b1;
          run_start_d = sig_wraddress;
          run_end_d   = sig_wraddress;
          run_sum_d   = mag;
          run_cnt_d   = 9'd1;
        end
        gap_d = 1'b0;
      end else if (run_open_d) begin
`ifdef CLUSTER_GAP_MERGE_EN
        if (!gap_d) gap_d = 1'b1;
        else        close_now = 1'b1;
`else
        close_now = 1'b1;
`endif
      end
      if (sig_ram_last && run_open_d) close_now = 1'b1;
      // Strict compare keeps the earlier run on equal sums.
      if (close_now) begin
        if (run_cnt_d >= MIN_W && run_sum_d > best_sum_d) begin
          best_valid_d = 1'b1;
          best_start_d = run_start_d;
          best_end_d   = run_end_d;
          best_sum_d   = run_sum_d;
        end
        run_open_d = 1'b0;
        gap_d      = 1'b0;
      end
      if (sig_ram_last) begin
        has_d = best_valid_d && bkg_sub_on && !seq_d;
        no_d  = !(best_valid_d && bkg_sub_on && !seq_d);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_open    <= 1'b0;
      gap_pending <= 1'b0;
      run_start   <= '0;
      run_end     <= '0;
      run_cnt     <= '0;
      run_sum     <= '0;
      best_valid  <= 1'b0;
      best_start  <= '0;
      best_end    <= '0;
      best_sum    <= '0;
      prev_addr   <= '0;
      seq_q       <= 1'b0;
      has_q       <= 1'b0;
      no_q        <= 1'b0;
    end else begin
      run_open    <= run_open_d;
      gap_pending <= gap_d;
      run_start   <= run_start_d;
      run_end     <= run_end_d;
      run_cnt     <= run_cnt_d;
      run_sum     <= run_sum_d;
      best_valid  <= best_valid_d;
      best_start  <= best_start_d;
      best_end    <= best_end_d;
      best_sum    <= best_sum_d;
      prev_addr   <= prev_addr_d;
      seq_q       <= seq_d;
      has_q       <= has_d;
      no_q        <= no_d;
    end
  end

  assign right_ext = {1'b0, best_end} + PAD_W;

  always_comb begin
    sig_ch_left  = '0;
    sig_ch_right = '0;
    cluster_sum  = '0;
    if (has_q) begin
      sig_ch_left  = ({1'b0, best_start} < PAD_W) ? 9'd0 : best_start - PAD_W[8:0];
      sig_ch_right = (right_ext > CH_MAX) ? CH_MAX[8:0] : right_ext[8:0];
      cluster_sum  = best_sum;
    end
  end

  assign has_cluster = has_q;
  assign no_cluster  = no_q;
  assign seq_error   = seq_q;

endmodule

// File: tb/tb_cluster_locate.sv
// Scoreboard bench for cluster_locate: directed frames push expected results, a monitor compares on completion.
module tb_cluster_locate;
  localparam int CH = 320;

  logic        clk = 1'b0, rst = 1'b1, bkg_sub_on = 1'b1;
  logic        sig_wren = 1'b0, sig_ram_last = 1'b0;
  logic [8:0]  sig_wraddress = '0;
  logic [31:0] sig_wrdata = '0;
  logic [15:0] threshold = 16'd100;
  logic [8:0]  sig_ch_left, sig_ch_right;
  logic        has_cluster, no_cluster, seq_error;
  logic [23:0] cluster_sum;

  cluster_locate #(.CH_NUM(CH), .MIN_WIDTH(2), .PAD(2)) dut (
    .clk(clk), .rst(rst), .bkg_sub_on(bkg_sub_on), .sig_wren(sig_wren),
    .sig_wraddress(sig_wraddress), .sig_wrdata(sig_wrdata), .sig_ram_last(sig_ram_last),
    .threshold(threshold), .sig_ch_left(sig_ch_left), .sig_ch_right(sig_ch_right),
    .has_cluster(has_cluster), .no_cluster(no_cluster), .cluster_sum(cluster_sum),
    .seq_error(seq_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0]  left;
    logic [8:0]  right;
    logic        has;
    logic        no;
    logic [23:0] sum;
    logic        seq;
  } res_t;

  res_t  exp_q[$];
  string name_q[$];
  int    n_vec = 0, n_err = 0;
  int    samp[CH];

  function automatic res_t mk(input int l, input int r, input bit h, input bit n, input int s, input bit q);
    res_t x;
    x.left = 9'(l); x.right = 9'(r); x.has = h; x.no = n; x.sum = 24'(s); x.seq = q;
    return x;
  endfunction

  function automatic res_t cur();
    return mk(int'(sig_ch_left), int'(sig_ch_right), has_cluster, no_cluster, int'(cluster_sum), seq_error);
  endfunction

  task automatic check(input string name, input res_t act, input res_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got left=%0d right=%0d has=%0d no=%0d sum=%0d seq=%0d, want left=%0d right=%0d has=%0d no=%0d sum=%0d seq=%0d",
               name, act.left, act.right, act.has, act.no, act.sum, act.seq,
               exp.left, exp.right, exp.has, exp.no, exp.sum, exp.seq);
    end
  endtask

  // Monitor: one comparison per frame completion (rising edge of has|no).
  initial begin : monitor
    logic done_q;
    res_t e;
    string nm;
    done_q = 1'b0;
    forever begin
      @(negedge clk);
      if ((has_cluster || no_cluster) && !done_q) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_result: got has=%0d no=%0d with nothing expected", has_cluster, no_cluster);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          check(nm, cur(), e);
        end
      end
      done_q = has_cluster | no_cluster;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input int a, input int d, input bit last);
    sig_wren      = 1'b1;
    sig_wraddress = 9'(a);
    sig_wrdata    = {16'h0000, 16'(d)};
    sig_ram_last  = last;
    @(posedge clk);
    #1;
    sig_wren     = 1'b0;
    sig_ram_last = 1'b0;
  endtask

  task automatic clear_samp(input int v);
    for (int i = 0; i < CH; i++) samp[i] = v;
  endtask

  task automatic set_range(input int lo, input int hi, input int v);
    for (int i = lo; i <= hi; i++) samp[i] = v;
  endtask

  task automatic expect_res(input string name, input res_t e);
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  task automatic run_frame(input string name, input res_t e);
    expect_res(name, e);
    for (int i = 0; i < CH; i++) begin
      wr(i, samp[i], i == CH - 1);
      if (i % 53 == 7) idle(1);
    end
    idle(3);
  endtask

  initial begin : stim
    #12;
    check("reset_state", cur(), mk(0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // sig_ram_last in IDLE: single-sample frame; a non-zero non-last write before it is ignored.
    wr(5, 500, 1'b0);
    expect_res("idle_last_one_sample", mk(0, 0, 0, 1, 0, 0));
    wr(CH - 1, 500, 1'b1);
    idle(3);

    clear_samp(0); set_range(100, 104, 500);
    run_frame("basic_run", mk(98, 106, 1, 0, 2500, 0));

    clear_samp(0); set_range(20, 22, 300); set_range(200, 201, 400);
    run_frame("two_runs_best_first", mk(18, 24, 1, 0, 900, 0));

    clear_samp(0); set_range(20, 22, 300); set_range(200, 202, 300);
    run_frame("tie_keeps_earlier", mk(18, 24, 1, 0, 900, 0));

    clear_samp(50);
    run_frame("all_below", mk(0, 0, 0, 1, 0, 0));

    clear_samp(0); set_range(100, 104, 100);
    run_frame("equal_threshold_not_above", mk(0, 0, 0, 1, 0, 0));

    clear_samp(0); set_range(100, 101, 101);
    run_frame("just_above", mk(98, 103, 1, 0, 202, 0));

    clear_samp(0); set_range(100, 104, 500);
    bkg_sub_on = 1'b0;
    run_frame("bkg_sub_off", mk(0, 0, 0, 1, 0, 0));
    bkg_sub_on = 1'b1;

    clear_samp(0); set_range(0, 1, 500);
    run_frame("left_clamp", mk(0, 3, 1, 0, 1000, 0));

    clear_samp(0); set_range(318, 319, 500);
    run_frame("right_clamp_last_close", mk(316, 319, 1, 0, 1000, 0));

    clear_samp(0); samp[150] = 500;
    run_frame("single_channel_rejected", mk(0, 0, 0, 1, 0, 0));

    // Skipped address 10 flags a sequence error and forces no_cluster.
    clear_samp(0); set_range(100, 104, 500);
    expect_res("seq_error", mk(0, 0, 0, 1, 0, 1));
    for (int i = 0; i < CH; i++) begin
      if (i != 10) wr(i, samp[i], i == CH - 1);
    end
    idle(3);

    // Partial frame with a large run, then an address-0 restart; only the restarted frame counts.
    clear_samp(0); set_range(10, 12, 5000);
    for (int i = 0; i <= 40; i++) wr(i, samp[i], 1'b0);
    clear_samp(0); set_range(100, 104, 500);
    run_frame("restart_at_addr0", mk(98, 106, 1, 0, 2500, 0));

    // Reset mid-frame at channel 160.
    clear_samp(0); set_range(20, 22, 300);
    for (int i = 0; i <= 160; i++) wr(i, samp[i], 1'b0);
    rst = 1'b1;
    #2;
    check("reset_midframe", cur(), mk(0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
    clear_samp(0); set_range(100, 104, 500);
    run_frame("after_reset_frame", mk(98, 106, 1, 0, 2500, 0));

    clear_samp(0); set_range(100, 101, 500); samp[103] = 500;
`ifdef CLUSTER_GAP_MERGE_EN
    run_frame("gap_merge", mk(98, 105, 1, 0, 1500, 0));
`else
    run_frame("gap_no_merge", mk(98, 103, 1, 0, 1000, 0));
`endif

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) idle(1);
    while (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      n_vec++;
      n_err++;
      $display("FAIL timeout_%s: got no completion, want a frame result", name_q.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
